control_contador_ms: RTL and testbench
======================================

CONTROL_CONTADOR_MS -- requirements
Module: control_contador_ms

Interface
REQ-001 The block SHALL have parameter ANCHO_MS, default 16, giving the width of the millisecond count.
REQ-002 The block SHALL have parameter ANCHO_PRE, default 19, giving the width of the prescaler and of the compare limit.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port iniciar SHALL be input, 1 bit: start/resume request, sampled each cycle.
REQ-006 Port detener SHALL be input, 1 bit: pause request, sampled each cycle.
REQ-007 Port limpiar SHALL be input, 1 bit: synchronous clear request, sampled each cycle.
REQ-008 Port limite SHALL be input, ANCHO_PRE bits: clock cycles per millisecond (e.g. 100000 at 100 MHz).
REQ-009 Port ms_cuenta SHALL be output, ANCHO_MS bits: registered elapsed-millisecond count.
REQ-010 Port tick_ms SHALL be output, 1 bit: registered one-cycle pulse per counted millisecond.
REQ-011 Port corriendo SHALL be output, 1 bit: high exactly while the state is CONTANDO.
REQ-012 Port desborde SHALL be output, 1 bit: high exactly while the state is DESBORDE.

Function
REQ-013 The block SHALL implement a four-state FSM: REPOSO, CONTANDO, PAUSA, DESBORDE.
REQ-014 Request priority SHALL be, per cycle: limpiar > detener > iniciar.
REQ-015 limpiar in any state SHALL, on the next edge, go to REPOSO and zero the prescaler, ms_cuenta and tick_ms.
REQ-016 REPOSO + iniciar SHALL go to CONTANDO with the prescaler at 0.
REQ-017 CONTANDO + detener SHALL go to PAUSA; prescaler and ms_cuenta SHALL be held, not cleared.
REQ-018 PAUSA + iniciar SHALL go to CONTANDO; counting SHALL resume from the held prescaler value.
REQ-019 detener in REPOSO, PAUSA or DESBORDE SHALL be ignored; iniciar in CONTANDO or DESBORDE SHALL be ignored.
REQ-020 In CONTANDO, the prescaler SHALL increment by 1 each cycle while prescaler < limite-1.
REQ-021 In CONTANDO with limite != 0 and prescaler >= limite-1 (terminal compare), the next edge SHALL: set the prescaler to 0, assert tick_ms for exactly one cycle, and increment ms_cuenta by 1.
REQ-022 The ">=" compare SHALL guarantee wrap on the next terminal cycle if limite is lowered below the current prescaler mid-run.
REQ-023 limite == 1 SHALL produce tick_ms on every cycle in CONTANDO; limite == 0 SHALL hold the prescaler at 0 and produce no ticks.
REQ-024 The tick_ms assertion and the new ms_cuenta value SHALL appear on the same edge; latency from terminal compare to outputs is 1 cycle.
REQ-025 A terminal compare while ms_cuenta == 2^ANCHO_MS-1 SHALL go to DESBORDE; ms_cuenta SHALL saturate (no wrap) and tick_ms SHALL still pulse once.
REQ-026 DESBORDE SHALL exit only via limpiar.
REQ-027 tick_ms SHALL be 0 in every cycle not following a terminal compare, including all PAUSA, REPOSO and DESBORDE cycles.
REQ-028 A detener on the same cycle as a terminal compare SHALL let that tick complete (prescaler to 0, ms_cuenta +1, tick_ms pulse) and enter PAUSA.

Reset
REQ-029 While rst is high: state SHALL be REPOSO; prescaler, ms_cuenta, tick_ms, corriendo and desborde SHALL all be 0, independent of clk.
REQ-030 rst asserted mid-count SHALL discard all progress; after release the block SHALL wait in REPOSO for iniciar.

Verification
REQ-031 limite=5, one-cycle iniciar -> tick_ms pulses every 5 cycles, first pulse 5 cycles after CONTANDO entry; ms_cuenta = 1,2,3 after 3 pulses.
REQ-032 limite=10, detener at prescaler=6, wait 20 cycles, iniciar -> ms_cuenta unchanged during PAUSA; next tick exactly 4 cycles after resume.
REQ-033 ANCHO_MS=4, limite=2, run 16 ms -> 16th tick sets ms_cuenta=15 and desborde=1, corriendo=0; further cycles keep ms_cuenta=15 and tick_ms=0.
REQ-034 Same cycle iniciar=detener=limpiar=1 while CONTANDO with ms_cuenta=7 -> next cycle REPOSO, ms_cuenta=0, corriendo=0.
REQ-035 limite=100, prescaler=80, then limite changed to 20 -> tick on next cycle, prescaler returns to 0, subsequent ticks every 20 cycles.
REQ-036 rst pulsed asynchronously (between clk edges) with ms_cuenta=3 -> all outputs 0 immediately; iniciar after release restarts from 0; limite=0 run -> no tick_ms in 50 cycles.

Source files
------------

// File: rtl/control_contador_ms_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_contador_ms_if
//  Description : Control and status bundle for the millisecond counter.
//                master : drives iniciar/detener/limpiar/limite, observes status
//                slave  : the counter itself (consumes requests, drives status)
//  Ports       : iniciar, detener, limpiar  - start / pause / clear requests
//                limite    [ANCHO_PRE]      - clock cycles per millisecond
//                ms_cuenta [ANCHO_MS]       - elapsed milliseconds
//                tick_ms, corriendo, desborde - status flags
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_contador_ms_if #(
    parameter int ANCHO_MS  = 16,
    parameter int ANCHO_PRE = 19
);
    logic                 iniciar;
    logic                 detener;
    logic                 limpiar;
    logic [ANCHO_PRE-1:0] limite;
    logic [ANCHO_MS-1:0]  ms_cuenta;
    logic                 tick_ms;
    logic                 corriendo;
    logic                 desborde;

    modport master (
        output iniciar, detener, limpiar, limite,
        input  ms_cuenta, tick_ms, corriendo, desborde
    );

    modport slave (
        input  iniciar, detener, limpiar, limite,
        output ms_cuenta, tick_ms, corriendo, desborde
    );
endinterface
`default_nettype wire

// File: rtl/control_contador_ms.sv
`default_nettype none
// ============================================================================
//  Module      : control_contador_ms
//  Description : Millisecond counter with start/pause/clear control. A
//                prescaler counts 'limite' clock cycles per millisecond; each
//                completed millisecond pulses tick_ms and bumps ms_cuenta,
//                which saturates and parks the block in DESBORDE.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - control_contador_ms_if.slave (requests in, status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module control_contador_ms #(
    parameter int ANCHO_MS  = 16,
    parameter int ANCHO_PRE = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    control_contador_ms_if.slave       bus
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSA    = 2'd2,
        DESBORDE = 2'd3
    } estado_t;

    localparam logic [ANCHO_PRE-1:0] c_pre_uno = {{(ANCHO_PRE-1){1'b0}}, 1'b1};
    localparam logic [ANCHO_MS-1:0]  c_ms_uno  = {{(ANCHO_MS-1){1'b0}}, 1'b1};
    localparam logic [ANCHO_MS-1:0]  c_ms_max  = {ANCHO_MS{1'b1}};

    estado_t              r_estado;
    estado_t              w_estado_nxt;
    logic [ANCHO_PRE-1:0] r_pre;
    logic [ANCHO_PRE-1:0] w_pre_nxt;
    logic [ANCHO_MS-1:0]  r_ms;
    logic [ANCHO_MS-1:0]  w_ms_nxt;
    logic                 r_tick;
    logic                 w_tick_nxt;
    logic                 w_limite_cero;
    logic                 w_terminal;

    // ">=" rather than "==" so a limite lowered below the running prescaler
    // still wraps on the very next cycle instead of counting to overflow.
    assign w_limite_cero = (bus.limite == '0);
    assign w_terminal    = !w_limite_cero && (r_pre >= (bus.limite - c_pre_uno));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= REPOSO;
            r_pre    <= '0;
            r_ms     <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_estado <= w_estado_nxt;
            r_pre    <= w_pre_nxt;
            r_ms     <= w_ms_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    always_comb begin
        w_estado_nxt = r_estado;
        w_pre_nxt    = r_pre;
        w_ms_nxt     = r_ms;
        w_tick_nxt   = 1'b0;

        if (bus.limpiar) begin
            w_estado_nxt = REPOSO;
            w_pre_nxt    = '0;
            w_ms_nxt     = '0;
        end else begin
            case (r_estado)
                REPOSO: begin
                    if (bus.iniciar) begin
                        w_estado_nxt = CONTANDO;
                        w_pre_nxt    = '0;
                    end
                end
                CONTANDO: begin
                    if (w_terminal) begin
                        // A pause request on the terminal cycle still lets
                        // this millisecond complete before pausing.
                        w_pre_nxt  = '0;
                        w_tick_nxt = 1'b1;
                        if (r_ms == c_ms_max) begin
                            w_estado_nxt = DESBORDE;
                        end else begin
                            w_ms_nxt = r_ms + c_ms_uno;
                            if (bus.detener) begin
                                w_estado_nxt = PAUSA;
                            end
                        end
                    end else if (bus.detener) begin
                        // Prescaler is frozen, not cleared, so resume
                        // continues the partial millisecond.
                        w_estado_nxt = PAUSA;
                    end else if (w_limite_cero) begin
                        w_pre_nxt = '0;
                    end else begin
                        w_pre_nxt = r_pre + c_pre_uno;
                    end
                end
                PAUSA: begin
                    if (bus.iniciar) begin
                        w_estado_nxt = CONTANDO;
                    end
                end
                DESBORDE: begin
                    w_estado_nxt = DESBORDE;
                end
                default: begin
                    w_estado_nxt = REPOSO;
                end
            endcase
        end
    end

    assign bus.ms_cuenta = r_ms;
    assign bus.tick_ms   = r_tick;
    assign bus.corriendo = (r_estado == CONTANDO);
    assign bus.desborde  = (r_estado == DESBORDE);

endmodule
`default_nettype wire

// File: tb/tb_control_contador_ms.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_contador_ms
//  Description : Self-checking bench for control_contador_ms. A 16-bit
//                instance covers the vector table and most sequences; a
//                4-bit instance covers saturation into DESBORDE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_contador_ms;

    logic clk;
    logic rst;

    control_contador_ms_if #(.ANCHO_MS(16), .ANCHO_PRE(19)) bus  ();
    control_contador_ms_if #(.ANCHO_MS(4),  .ANCHO_PRE(19)) bus4 ();

    control_contador_ms #(.ANCHO_MS(16), .ANCHO_PRE(19)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    control_contador_ms #(.ANCHO_MS(4), .ANCHO_PRE(19)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct packed {
        logic        ini;
        logic        det;
        logic        lmp;
        logic [18:0] lim;
        logic [15:0] ms;
        logic        tick;
        logic        corr;
        logic        desb;
    } vec_t;

    typedef struct packed {
        logic [15:0] ms;
        logic        tick;
        logic        corr;
        logic        desb;
    } exp_t;

    vec_t tabla [20];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input logic i, input logic d, input logic l,
                               input logic [18:0] lim, input logic [15:0] ms,
                               input logic t, input logic c, input logic de);
        vec_t r;
        r.ini = i; r.det = d; r.lmp = l; r.lim = lim;
        r.ms = ms; r.tick = t; r.corr = c; r.desb = de;
        return r;
    endfunction

    task automatic check(input string nombre, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nombre, got, exp);
        end
    endtask

    // Inputs change #1 after the rising edge; outputs are sampled there too.
    task automatic cyc(input logic ini, input logic det, input logic lmp, input logic [18:0] lim);
        bus.iniciar = ini; bus.detener = det; bus.limpiar = lmp; bus.limite = lim;
        @(posedge clk); #1;
    endtask

    task automatic cyc4(input logic ini, input logic det, input logic lmp, input logic [18:0] lim);
        bus4.iniciar = ini; bus4.detener = det; bus4.limpiar = lmp; bus4.limite = lim;
        @(posedge clk); #1;
    endtask

    // Idle cycles until tick_ms; n = cycles taken, -1 if none within max.
    task automatic wait_tick(input logic [18:0] lim, input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            cyc(1'b0, 1'b0, 1'b0, lim);
            if (bus.tick_ms) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_ms(input logic [15:0] objetivo, input logic [18:0] lim, input int max, input string nombre);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            cyc(1'b0, 1'b0, 1'b0, lim);
            if (bus.ms_cuenta == objetivo) begin
                ok = 1'b1;
                break;
            end
        end
        check(nombre, 32'(ok), 32'd1);
    endtask

    initial begin
        int   n;
        int   malos;
        int   ticks;
        exp_t e;

        tabla[0]  = v(1'b1, 1'b0, 1'b0, 19'd3, 16'd0, 1'b0, 1'b1, 1'b0);
        tabla[1]  = v(1'b0, 1'b0, 1'b0, 19'd3, 16'd0, 1'b0, 1'b1, 1'b0);
        tabla[2]  = v(1'b0, 1'b0, 1'b0, 19'd3, 16'd0, 1'b0, 1'b1, 1'b0);
        tabla[3]  = v(1'b0, 1'b0, 1'b0, 19'd3, 16'd1, 1'b1, 1'b1, 1'b0);
        tabla[4]  = v(1'b0, 1'b0, 1'b0, 19'd3, 16'd1, 1'b0, 1'b1, 1'b0);
        tabla[5]  = v(1'b0, 1'b0, 1'b0, 19'd3, 16'd1, 1'b0, 1'b1, 1'b0);
        tabla[6]  = v(1'b0, 1'b1, 1'b0, 19'd3, 16'd2, 1'b1, 1'b0, 1'b0);
        tabla[7]  = v(1'b0, 1'b0, 1'b0, 19'd3, 16'd2, 1'b0, 1'b0, 1'b0);
        tabla[8]  = v(1'b0, 1'b1, 1'b0, 19'd3, 16'd2, 1'b0, 1'b0, 1'b0);
        tabla[9]  = v(1'b1, 1'b0, 1'b0, 19'd3, 16'd2, 1'b0, 1'b1, 1'b0);
        tabla[10] = v(1'b0, 1'b0, 1'b0, 19'd3, 16'd2, 1'b0, 1'b1, 1'b0);
        tabla[11] = v(1'b1, 1'b0, 1'b0, 19'd3, 16'd2, 1'b0, 1'b1, 1'b0);
        tabla[12] = v(1'b0, 1'b0, 1'b0, 19'd3, 16'd3, 1'b1, 1'b1, 1'b0);
        tabla[13] = v(1'b0, 1'b1, 1'b0, 19'd3, 16'd3, 1'b0, 1'b0, 1'b0);
        tabla[14] = v(1'b0, 1'b0, 1'b1, 19'd3, 16'd0, 1'b0, 1'b0, 1'b0);
        tabla[15] = v(1'b0, 1'b1, 1'b0, 19'd3, 16'd0, 1'b0, 1'b0, 1'b0);
        tabla[16] = v(1'b1, 1'b0, 1'b0, 19'd1, 16'd0, 1'b0, 1'b1, 1'b0);
        tabla[17] = v(1'b0, 1'b0, 1'b0, 19'd1, 16'd1, 1'b1, 1'b1, 1'b0);
        tabla[18] = v(1'b0, 1'b0, 1'b0, 19'd1, 16'd2, 1'b1, 1'b1, 1'b0);
        tabla[19] = v(1'b1, 1'b1, 1'b1, 19'd1, 16'd0, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        bus.iniciar  = 1'b0; bus.detener  = 1'b0; bus.limpiar  = 1'b0; bus.limite  = '0;
        bus4.iniciar = 1'b0; bus4.detener = 1'b0; bus4.limpiar = 1'b0; bus4.limite = '0;

        // Reset state, checked before any clock edge.
        #2;
        check("rst_ms",    32'(bus.ms_cuenta), 32'd0);
        check("rst_tick",  32'(bus.tick_ms),   32'd0);
        check("rst_corr",  32'(bus.corriendo), 32'd0);
        check("rst_desb",  32'(bus.desborde),  32'd0);
        check("rst4_ms",   32'(bus4.ms_cuenta), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Vector table through the scoreboard.
        for (int i = 0; i < 20; i++) begin
            e.ms = tabla[i].ms; e.tick = tabla[i].tick;
            e.corr = tabla[i].corr; e.desb = tabla[i].desb;
            sb.push_back(e);
            cyc(tabla[i].ini, tabla[i].det, tabla[i].lmp, tabla[i].lim);
            e = sb.pop_front();
            check($sformatf("v%0d_ms", i),   32'(bus.ms_cuenta), 32'(e.ms));
            check($sformatf("v%0d_tick", i), 32'(bus.tick_ms),   32'(e.tick));
            check($sformatf("v%0d_corr", i), 32'(bus.corriendo), 32'(e.corr));
            check($sformatf("v%0d_desb", i), 32'(bus.desborde),  32'(e.desb));
        end

        // limite=5: ticks every 5 cycles from CONTANDO entry.
        cyc(1'b0, 1'b0, 1'b1, 19'd5);
        cyc(1'b1, 1'b0, 1'b0, 19'd5);
        for (int k = 1; k <= 3; k++) begin
            wait_tick(19'd5, 20, n);
            check($sformatf("l5_periodo%0d", k), 32'(n), 32'd5);
            check($sformatf("l5_ms%0d", k), 32'(bus.ms_cuenta), 32'(k));
        end

        // limite=10: pause at prescaler 6, resume, tick 4 cycles later.
        cyc(1'b0, 1'b0, 1'b1, 19'd10);
        cyc(1'b1, 1'b0, 1'b0, 19'd10);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 19'd10);
        cyc(1'b0, 1'b1, 1'b0, 19'd10);
        check("pausa_corr", 32'(bus.corriendo), 32'd0);
        malos = 0;
        repeat (20) begin
            cyc(1'b0, 1'b0, 1'b0, 19'd10);
            if (bus.ms_cuenta != 16'd0 || bus.tick_ms || bus.corriendo) malos++;
        end
        check("pausa_estable", 32'(malos), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 19'd10);
        wait_tick(19'd10, 20, n);
        check("reanuda_lat", 32'(n), 32'd4);
        check("reanuda_ms", 32'(bus.ms_cuenta), 32'd1);

        // All three requests at once with ms_cuenta=7: clear wins.
        cyc(1'b0, 1'b0, 1'b1, 19'd2);
        cyc(1'b1, 1'b0, 1'b0, 19'd2);
        wait_ms(16'd7, 19'd2, 100, "llega_ms7");
        cyc(1'b1, 1'b1, 1'b1, 19'd2);
        check("tres_ms",   32'(bus.ms_cuenta), 32'd0);
        check("tres_corr", 32'(bus.corriendo), 32'd0);
        check("tres_tick", 32'(bus.tick_ms),   32'd0);

        // limite lowered from 100 to 20 with prescaler at 80.
        cyc(1'b0, 1'b0, 1'b1, 19'd100);
        cyc(1'b1, 1'b0, 1'b0, 19'd100);
        repeat (80) cyc(1'b0, 1'b0, 1'b0, 19'd100);
        check("l100_sin_tick", 32'(bus.ms_cuenta), 32'd0);
        wait_tick(19'd20, 5, n);
        check("baja_lim_inmediato", 32'(n), 32'd1);
        wait_tick(19'd20, 40, n);
        check("baja_lim_periodo1", 32'(n), 32'd20);
        wait_tick(19'd20, 40, n);
        check("baja_lim_periodo2", 32'(n), 32'd20);

        // Asynchronous reset mid-count with ms_cuenta=3.
        cyc(1'b0, 1'b0, 1'b1, 19'd4);
        cyc(1'b1, 1'b0, 1'b0, 19'd4);
        wait_ms(16'd3, 19'd4, 100, "llega_ms3");
        #2 rst = 1'b1;
        #1;
        check("arst_ms",   32'(bus.ms_cuenta), 32'd0);
        check("arst_tick", 32'(bus.tick_ms),   32'd0);
        check("arst_corr", 32'(bus.corriendo), 32'd0);
        check("arst_desb", 32'(bus.desborde),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 19'd4);
        check("arst_reposo", 32'(bus.corriendo), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 19'd4);
        check("arst_inicia", 32'(bus.corriendo), 32'd1);
        wait_tick(19'd4, 20, n);
        check("arst_lat", 32'(n), 32'd4);
        check("arst_ms1", 32'(bus.ms_cuenta), 32'd1);

        // limite=0: no ticks while running.
        cyc(1'b0, 1'b0, 1'b1, 19'd0);
        cyc(1'b1, 1'b0, 1'b0, 19'd0);
        ticks = 0;
        repeat (50) begin
            cyc(1'b0, 1'b0, 1'b0, 19'd0);
            if (bus.tick_ms) ticks++;
        end
        check("lim0_ticks", 32'(ticks), 32'd0);
        check("lim0_ms",    32'(bus.ms_cuenta), 32'd0);
        check("lim0_corr",  32'(bus.corriendo), 32'd1);

        // 4-bit instance: 16 ms saturates into DESBORDE.
        cyc4(1'b1, 1'b0, 1'b0, 19'd2);
        ticks = 0;
        for (int k = 0; k < 200; k++) begin
            cyc4(1'b0, 1'b0, 1'b0, 19'd2);
            if (bus4.tick_ms) begin
                ticks++;
                if (ticks == 15) begin
                    check("sat15_ms",   32'(bus4.ms_cuenta), 32'd15);
                    check("sat15_desb", 32'(bus4.desborde),  32'd0);
                end
                if (ticks == 16) break;
            end
        end
        check("sat_ticks", 32'(ticks), 32'd16);
        check("sat_ms",    32'(bus4.ms_cuenta), 32'd15);
        check("sat_desb",  32'(bus4.desborde),  32'd1);
        check("sat_corr",  32'(bus4.corriendo), 32'd0);
        malos = 0;
        repeat (10) begin
            cyc4(1'b1, 1'b1, 1'b0, 19'd2);
            if (bus4.ms_cuenta != 4'd15 || bus4.tick_ms || !bus4.desborde) malos++;
        end
        check("sat_retiene", 32'(malos), 32'd0);
        cyc4(1'b0, 1'b0, 1'b1, 19'd2);
        check("sat_limpia_desb", 32'(bus4.desborde),  32'd0);
        check("sat_limpia_ms",   32'(bus4.ms_cuenta), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
